rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares the 16:1 single-bit `mux` datapath among 16 requesters. It grants one requester at a time and drives the mux `sel` with the granted index. It holds the grant until the owner releases it, or until a hold timeout when that is compiled in. It sits directly in front of the `mux` instance and is the only driver of its select input.

## Interface

Parameters:
- `N`, 16, number of requesters; must equal the mux input count.
- `SEL_W`, 4, select width; must equal clog2(`N`).
- `MAX_HOLD`, 8, maximum grant length in cycles when the timeout feature is compiled in; legal range 1..255.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  N  per-requester request, level-sensitive.
- `done`  input  1  owner release strobe; sampled only in GRANT.
- `grant`  output  N  one-hot grant, all-zero when idle; registered.
- `sel`  output  SEL_W  index of the granted requester, driven to the mux `sel`; registered.
- `valid`  output  1  high while a grant is active; mux `out` is meaningful only while high.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation

- Two states: IDLE and GRANT. All state and outputs are registered.
- Priority pointer `ptr` (SEL_W bits) names the highest-priority requester.
- IDLE:
  - If `req` is all-zero, stay in IDLE.
  - Otherwise select the first set bit of `req` scanning `ptr`, `ptr+1`, … modulo N, wrapping 15→0.
  - Load `sel`, `grant`, `valid=1`, clear the hold counter, go to GRANT.
- GRANT: release when any of the following is true at a clock edge:
  - (a) `done`=1;
  - (b) `req[sel]`=0 (owner dropped its request);
  - (c) the timeout feature is compiled in and the hold counter equals `MAX_HOLD-1`.
- On release:
  - `grant`←0 and `valid`←0; `sel` keeps its last value.
  - `ptr`←`sel+1` modulo N (wraps 15→0).
  - Go to IDLE.
- Simultaneous release conditions are one release.
- `timeout` pulses only when (c) is the sole cause, not also (a) or (b).
- Requests from non-owners during GRANT are ignored until the next IDLE cycle; there is no preemption.
- The hold counter is 8 bits and counts cycles spent in GRANT; it is irrelevant when the feature is compiled out.
- Reset values: state IDLE, `ptr`=0, `grant`=0, `sel`=0, `valid`=0, `timeout`=0, counter 0.
- Reset asserted mid-grant forces all of the above at the next edge, regardless of `req` and `done`.

## Timing

- Grant latency: `req` visible at edge k in IDLE → `grant`, `sel`, `valid` valid after edge k (one cycle).
- Release latency: release condition at edge k → `valid`=0 after edge k.
- Minimum one IDLE cycle between consecutive grants; peak throughput is one grant per 2 cycles.
- A grant therefore lasts at least 1 cycle; with the timeout compiled in it lasts at most `MAX_HOLD` cycles.
- `timeout` is high for exactly the cycle in which `valid` first reads 0 after the revoked grant.
- `grant` is always one-hot or zero, and `grant[sel]`=`valid`.

## Configuration

- `ARB_TIMEOUT_EN` defined:
  - Hold counter and release condition (c) are present.
  - `timeout` behaves as specified above.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - A grant lasts until `done` or the owner drops `req`.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is ignored.

## Test plan

- Reset/idle: assert `rst` 2 cycles with `req`=16'hFFFF → `grant`=0, `sel`=0, `valid`=0. Release reset with `req`=0 → stays idle.
- Round-robin rotation:
  - Stimulus: `req`=16'h3f0a held, `done` pulsed one cycle after each grant.
  - Required grants: `sel` sequence 1, 3, 8, 9, 10, 11, 12, 13, then 1.
  - Each grant separated by one `valid`=0 cycle; `grant`=16'h0002 for `sel`=1.
- Wrap-around: force `ptr`=14 by granting and releasing requester 13 with `req`=16'h2000. Then `req`=16'h0041 → `sel`=0 granted before 6. Next grant is 6.
- Owner drop and no preemption:
  - Grant `sel`=6 with `req`=16'h0040.
  - Raise `req[2]` mid-grant → `sel` stays 6.
  - Drop `req[6]` → `valid`=0 next cycle, then `sel`=2.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=8):
  - Stimulus: `req`=16'h1000 held, `done`=0.
  - Required: `valid` high exactly 8 cycles with `sel`=12, then `timeout`=1 for one cycle, then re-grant of 12.
  - Without the macro: `valid` stays high for 50+ cycles and `timeout` stays 0.
- Reset mid-grant and mux check:
  - Drive the `mux` with `in`=16'h3f0a; while `sel`=3 check `out`=1; while `sel`=2 check `out`=0.
  - Assert `rst` during a grant → all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_mux_arbiter                                                       |
// | Round-robin owner arbiter driving the select of a 16:1 mux.          |
// | Optional hold-timeout revocation built when ARB_TIMEOUT_EN defined.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_mux_arbiter #(
  parameter int N        = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             timeout
);

  localparam logic [0:0]       c_st_idle  = 1'b0;
  localparam logic [0:0]       c_st_grant = 1'b1;
  localparam logic [SEL_W:0]   c_n        = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] c_last     = SEL_W'(N-1);
  localparam logic [N-1:0]     c_one      = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, r_sel, w_ptr_nxt, w_sel_nxt, w_pick, w_sel_inc;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_found;
  logic             w_rel_owner, w_rel_hold, w_release;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic [SEL_W:0] w_sum;
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (w_sum >= c_n) begin
        w_sum = w_sum - c_n;
      end
      if (!w_found && req[w_sum[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[SEL_W-1:0];
      end
    end
  end

  assign w_sel_inc   = (r_sel == c_last) ? '0 : r_sel + 1'b1;
  assign w_rel_owner = done || !req[r_sel];
  assign w_release   = (r_state == c_st_grant) && (w_rel_owner || w_rel_hold);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold;

  always_ff @(posedge clk) begin
    if (rst || r_state == c_st_idle) begin
      r_hold <= '0;
    end else if (!w_release) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  assign w_rel_hold = (r_state == c_st_grant) && (r_hold == c_hold_last);
`else
  logic w_unused_hold;
  assign w_unused_hold = (MAX_HOLD != 0);
  assign w_rel_hold    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sel     <= w_sel_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_found)   w_state_nxt = c_st_grant;
      c_st_grant: if (w_release) w_state_nxt = c_st_idle;
      default:                   w_state_nxt = c_st_idle;
    endcase
  end

  // sel holds its last value after release so the mux select stays quiet.
  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_sel_nxt     = r_sel;
    w_grant_nxt   = r_grant;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_grant_nxt = c_one << w_pick;
          w_valid_nxt = 1'b1;
        end
      end
      c_st_grant: begin
        if (w_release) begin
          w_grant_nxt   = '0;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = w_sel_inc;
          w_timeout_nxt = w_rel_hold && !w_rel_owner;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_mux_arbiter                                                    |
// | Directed vector table plus randomized run against a reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rr_mux_arbiter;

  localparam int N        = 16;
  localparam int SEL_W    = 4;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit c_to_en = 1'b1;
`else
  localparam bit c_to_en = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             timeout;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: who owns the mux, priority pointer, hold length.
  bit m_busy;
  int m_sel, m_ptr, m_hold;
  bit m_to;

  logic [15:0] mux_in = 16'h3f0a;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        exp_valid;
    logic [3:0]  exp_sel;
    logic [15:0] exp_grant;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rd, rt;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_sel = 0; m_to = 0; m_hold = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int i = 0; i < N; i++) begin
        if (req[(m_ptr + i) % N]) begin
          m_sel  = (m_ptr + i) % N;
          m_busy = 1;
          m_hold = 0;
          break;
        end
      end
    end else begin
      rd = done || !req[m_sel];
      rt = c_to_en && (m_hold == MAX_HOLD - 1);
      if (rd || rt) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % N;
        m_to   = rt && !rd;
      end else begin
        m_hold++;
        m_to = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, valid, m_busy);
    check({tag, ".sel"}, sel, m_sel);
    check({tag, ".grant"}, grant, m_busy ? (16'h1 << m_sel) : 16'h0);
    check({tag, ".timeout"}, timeout, m_to);
  endtask

  task automatic add(input logic r, input logic [15:0] q, input logic d, input logic v, input int s);
    vec_t e;
    e.rst       = r;
    e.req       = q;
    e.done      = d;
    e.exp_valid = v;
    e.exp_sel   = 4'(s);
    e.exp_grant = v ? (16'h1 << s) : 16'h0;
    vq.push_back(e);
  endtask

  initial begin
    int rot[9] = '{1, 3, 8, 9, 10, 11, 12, 13, 1};
    rst = 1'b1; req = '0; done = 1'b0;

    // Reset with all requesting, then idle.
    add(1, 16'hFFFF, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0);
    // Rotation over 16'h3f0a, done one cycle after each grant.
    foreach (rot[i]) begin
      add(0, 16'h3f0a, 0, 1, rot[i]);
      add(0, 16'h3f0a, 1, 0, rot[i]);
    end
    // Wrap-around: pointer to 14, then 0 wins before 6.
    add(0, 16'h2000, 0, 1, 13);
    add(0, 16'h2000, 1, 0, 13);
    add(0, 16'h0041, 0, 1, 0);
    add(0, 16'h0041, 1, 0, 0);
    add(0, 16'h0041, 0, 1, 6);
    // No preemption, then owner drop.
    add(0, 16'h0044, 0, 1, 6);
    add(0, 16'h0004, 0, 0, 6);
    add(0, 16'h0004, 0, 1, 2);
    // Reset mid-grant, then regrant from pointer 0.
    add(1, 16'h0004, 0, 0, 0);
    add(0, 16'h0004, 0, 1, 2);
    add(0, 16'h0004, 1, 0, 2);

    foreach (vq[i]) begin
      rst = vq[i].rst; req = vq[i].req; done = vq[i].done;
      step();
      check($sformatf("vec%0d.valid", i), valid, vq[i].exp_valid);
      check($sformatf("vec%0d.sel", i), sel, vq[i].exp_sel);
      check($sformatf("vec%0d.grant", i), grant, vq[i].exp_grant);
      check($sformatf("vec%0d.timeout", i), timeout, 1'b0);
      if (vq[i].exp_valid)
        check($sformatf("vec%0d.muxout", i), mux_in[sel], mux_in[vq[i].exp_sel]);
    end

    // Hold limit: requester 12 alone, never releases on its own.
    req = 16'h1000; done = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 17; c++) begin
      step();
      check($sformatf("hold%0d.valid", c), valid, (c < 8) || (c >= 9));
      check($sformatf("hold%0d.timeout", c), timeout, c == 8);
      check($sformatf("hold%0d.sel", c), sel, 4'd12);
    end
    // done coinciding with the hold limit: plain release, no pulse.
    done = 1'b1;
    step();
    check("hold_both.valid", valid, 1'b0);
    check("hold_both.timeout", timeout, 1'b0);
`else
    for (int c = 0; c < 55; c++) begin
      step();
      check($sformatf("hold%0d.valid", c), valid, 1'b1);
      check($sformatf("hold%0d.timeout", c), timeout, 1'b0);
      check($sformatf("hold%0d.sel", c), sel, 4'd12);
    end
    done = 1'b1;
    step();
    check("hold_end.valid", valid, 1'b0);
    check("hold_end.timeout", timeout, 1'b0);
`endif
    done = 1'b0; req = '0;
    step();
    check_model("sync");

    // Randomized traffic against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = 16'($urandom) & 16'($urandom);
          1:       req = 16'h1 << $urandom_range(0, 15);
          default: req = 16'($urandom);
        endcase
      end
      done = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
